// File: rtl/aes_block_sequencer.sv
// Block-mode sequencer around an external AES core: gathers stream chunks into a block,
// applies ECB/CBC chaining around the core, and streams the result back out chunk by chunk.
module aes_block_sequencer #(
    parameter int BLOCK_W  = 128,
    parameter int STREAM_W = 32,
    parameter int CNT_W    = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   clear_i,
    input  logic                                   start_i,
    input  logic [CNT_W-1:0]                       num_blocks_i,
    input  logic [1:0]                             mode_i,
    input  logic [BLOCK_W-1:0]                     iv_i,
    input  logic [STREAM_W-1:0]                    in_data_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    output logic                                   core_start_o,
    output logic [BLOCK_W-1:0]                     core_data_o,
    input  logic                                   core_done_i,
    input  logic [BLOCK_W-1:0]                     core_result_i,
    output logic [STREAM_W-1:0]                    out_data_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [CNT_W-1:0]                       block_cnt_o,
    output logic [$clog2(BLOCK_W/STREAM_W):0]      chunk_cnt_o
);

    localparam int CHUNKS = BLOCK_W / STREAM_W;
    localparam int CCW    = $clog2(CHUNKS) + 1;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CCW-1:0] LAST_CHUNK = CCW'(CHUNKS - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_CORE_START = 3'd2;
    localparam logic [2:0] S_CORE_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN      = 3'd4;
    localparam logic [2:0] S_FINISHED   = 3'd5;

    localparam logic [1:0] MODE_CBC_ENC = 2'b01;
    localparam logic [1:0] MODE_CBC_DEC = 2'b10;

    logic [2:0]         state_reg, state_next;
    logic [1:0]         mode_reg, mode_next;
    logic [CNT_W-1:0]   total_reg, total_next;
    logic [CNT_W-1:0]   block_cnt_reg, block_cnt_next;
    logic [CCW-1:0]     chunk_cnt_reg, chunk_cnt_next;
    logic [BLOCK_W-1:0] chain_reg, chain_next;
    logic [BLOCK_W-1:0] block_reg, block_next;
    logic [BLOCK_W-1:0] buf_reg, buf_next;
    logic [BLOCK_W-1:0] core_data_reg, core_data_next;

    logic [IDX_W-1:0]    chunk_idx;
    logic [BLOCK_W-1:0]  block_loaded;
    logic [STREAM_W-1:0] buf_chunks [CHUNKS];
    logic [CNT_W-1:0]    block_cnt_inc;
    logic                is_cbc_enc;
    logic                is_cbc_dec;

    assign chunk_idx     = chunk_cnt_reg[IDX_W-1:0];
    assign block_cnt_inc = block_cnt_reg + CNT_W'(1);
    assign is_cbc_enc    = (mode_reg == MODE_CBC_ENC);
    assign is_cbc_dec    = (mode_reg == MODE_CBC_DEC);

    // block_loaded is the input block with the current chunk merged in, so the
    // last chunk can feed the core word in the same cycle it is accepted.
    genvar gi;
    generate
        for (gi = 0; gi < CHUNKS; gi++) begin : g_chunk
            assign block_loaded[gi*STREAM_W +: STREAM_W] =
                (chunk_idx == IDX_W'(gi)) ? in_data_i : block_reg[gi*STREAM_W +: STREAM_W];
            assign buf_chunks[gi] = buf_reg[gi*STREAM_W +: STREAM_W];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        total_next     = total_reg;
        block_cnt_next = block_cnt_reg;
        chunk_cnt_next = chunk_cnt_reg;
        chain_next     = chain_reg;
        block_next     = block_reg;
        buf_next       = buf_reg;
        core_data_next = core_data_reg;

        if (clear_i) begin
            state_next     = S_IDLE;
            mode_next      = '0;
            total_next     = '0;
            block_cnt_next = '0;
            chunk_cnt_next = '0;
            chain_next     = '0;
            block_next     = '0;
            buf_next       = '0;
            core_data_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        block_cnt_next = '0;
                        chunk_cnt_next = '0;
                        if (num_blocks_i != '0) begin
                            total_next = num_blocks_i;
                            mode_next  = mode_i;
                            chain_next = iv_i;
                            state_next = S_LOAD;
                        end else begin
                            state_next = S_FINISHED;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid_i) begin
                        block_next = block_loaded;
                        if (chunk_cnt_reg == LAST_CHUNK) begin
                            chunk_cnt_next = '0;
                            core_data_next = is_cbc_enc ? (block_loaded ^ chain_reg) : block_loaded;
                            state_next     = S_CORE_START;
                        end else begin
                            chunk_cnt_next = chunk_cnt_reg + CCW'(1);
                        end
                    end
                end
                S_CORE_START: begin
                    state_next = S_CORE_WAIT;
                end
                S_CORE_WAIT: begin
                    if (core_done_i) begin
                        buf_next = is_cbc_dec ? (core_result_i ^ chain_reg) : core_result_i;
                        if (is_cbc_enc) begin
                            chain_next = core_result_i;
                        end else if (is_cbc_dec) begin
                            chain_next = block_reg;
                        end
                        chunk_cnt_next = '0;
                        state_next     = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready_i) begin
                        if (chunk_cnt_reg == LAST_CHUNK) begin
                            chunk_cnt_next = '0;
                            block_cnt_next = block_cnt_inc;
                            state_next     = (block_cnt_inc == total_reg) ? S_FINISHED : S_LOAD;
                        end else begin
                            chunk_cnt_next = chunk_cnt_reg + CCW'(1);
                        end
                    end
                end
                S_FINISHED: begin
                    chunk_cnt_next = '0;
                    state_next     = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= S_IDLE;
            mode_reg      <= '0;
            total_reg     <= '0;
            block_cnt_reg <= '0;
            chunk_cnt_reg <= '0;
            chain_reg     <= '0;
            block_reg     <= '0;
            buf_reg       <= '0;
            core_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            total_reg     <= total_next;
            block_cnt_reg <= block_cnt_next;
            chunk_cnt_reg <= chunk_cnt_next;
            chain_reg     <= chain_next;
            block_reg     <= block_next;
            buf_reg       <= buf_next;
            core_data_reg <= core_data_next;
        end
    end

    assign busy_o       = (state_reg != S_IDLE);
    assign done_o       = (state_reg == S_FINISHED);
    assign in_ready_o   = (state_reg == S_LOAD);
    assign core_start_o = (state_reg == S_CORE_START);
    assign out_valid_o  = (state_reg == S_DRAIN);
    assign core_data_o  = core_data_reg;
    assign out_data_o   = (state_reg == S_DRAIN) ? buf_chunks[chunk_idx] : '0;
    assign block_cnt_o  = block_cnt_reg;
    assign chunk_cnt_o  = chunk_cnt_reg;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer: directed ECB/CBC jobs against a behavioural core,
// plus zero-length, soft-clear and asynchronous-reset scenarios.
module tb_aes_block_sequencer;

    localparam int BW  = 128;
    localparam int SW  = 32;
    localparam int CW  = 16;
    localparam int NCH = BW / SW;

    logic          clk_i, rst_i, clear_i, start_i;
    logic [CW-1:0] num_blocks_i;
    logic [1:0]    mode_i;
    logic [BW-1:0] iv_i;
    logic [SW-1:0] in_data_i;
    logic          in_valid_i, in_ready_o;
    logic          core_start_o, core_done_i;
    logic [BW-1:0] core_data_o, core_result_i;
    logic [SW-1:0] out_data_o;
    logic          out_valid_o, out_ready_i;
    logic          busy_o, done_o;
    logic [CW-1:0] block_cnt_o;
    logic [2:0]    chunk_cnt_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int core_starts  = 0;
    int cyc          = 0;
    bit done_prev    = 0;
    bit core_hold    = 0;
    bit stall_en     = 0;
    bit ready_force0 = 0;
    logic [BW-1:0] core_key = '0;

    logic [SW-1:0] exp_out_q [$];
    logic [BW-1:0] exp_core_q [$];

    localparam logic [BW-1:0] IV = 128'h00010203_04050607_08090A0B_0C0D0E0F;

    aes_block_sequencer #(.BLOCK_W(BW), .STREAM_W(SW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .num_blocks_i(num_blocks_i), .mode_i(mode_i), .iv_i(iv_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .core_start_o(core_start_o), .core_data_o(core_data_o),
        .core_done_i(core_done_i), .core_result_i(core_result_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o), .block_cnt_o(block_cnt_o), .chunk_cnt_o(chunk_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Output monitor: every accepted chunk must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (out_valid_o && out_ready_i) begin
            if (exp_out_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL out_unexpected actual=%h required=no_output", out_data_o);
            end else begin
                logic [SW-1:0] e;
                e = exp_out_q.pop_front();
                $display("[TB] out chunk %h (expected %h)", out_data_o, e);
                check("out_chunk", BW'(out_data_o), BW'(e));
            end
        end
    end

    always @(negedge clk_i) begin
        if (core_start_o) begin
            core_starts++;
            if (exp_core_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL core_unexpected actual=%h required=no_start", core_data_o);
            end else begin
                logic [BW-1:0] e;
                e = exp_core_q.pop_front();
                $display("[TB] core start data %h", core_data_o);
                check("core_data", core_data_o, e);
            end
        end
    end

    always @(negedge clk_i) begin
        if (done_o) begin
            done_cnt++;
            $display("[TB] done pulse, block_cnt=%0d", block_cnt_o);
            check_int("done_one_cycle", int'(done_prev), 0);
        end
        done_prev = done_o;
    end

    // Behavioural AES core: result = data ^ core_key after a fixed latency.
    initial begin
        logic [BW-1:0] cap;
        forever begin
            @(negedge clk_i);
            if (core_start_o && !core_hold) begin
                cap = core_data_o;
                repeat (3) begin
                    @(negedge clk_i);
                    check("core_data_stable", core_data_o, cap);
                end
                core_result_i = cap ^ core_key;
                core_done_i   = 1'b1;
                @(negedge clk_i);
                core_done_i   = 1'b0;
            end
        end
    end

    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            out_ready_i = ready_force0 ? 1'b0 : (stall_en ? ((cyc % 3) != 0) : 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic push_block_out(input logic [BW-1:0] b);
        for (int k = 0; k < NCH; k++) exp_out_q.push_back(b[k*SW +: SW]);
    endtask

    task automatic send_chunk(input logic [SW-1:0] d);
        int t;
        in_valid_i = 1'b1;
        in_data_i  = d;
        t = 0;
        while (!in_ready_o && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 500) timeout_fail("in_ready_wait");
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_data_i  = '0;
    endtask

    task automatic send_block(input logic [BW-1:0] b, input int gap);
        for (int k = 0; k < NCH; k++) begin
            repeat (gap * (k % 2)) @(negedge clk_i);
            send_chunk(b[k*SW +: SW]);
        end
    endtask

    task automatic start_job(input int nb, input logic [1:0] mode, input logic [BW-1:0] iv);
        num_blocks_i = CW'(nb);
        mode_i       = mode;
        iv_i         = iv;
        start_i      = 1'b1;
        @(negedge clk_i);
        start_i      = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int t;
        t = 0;
        while (done_cnt == prev && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 2000) timeout_fail("done_wait");
    endtask

    initial begin
        int prev;
        int cs;
        int t;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; num_blocks_i = '0; mode_i = '0;
        iv_i = '0; in_valid_i = 1'b0; in_data_i = '0; core_done_i = 1'b0; core_result_i = '0;

        #12;
        check_int("rst_flags", int'({busy_o, done_o, in_ready_o, out_valid_o, core_start_o}), 0);
        check("rst_core_data", core_data_o, '0);
        check_int("rst_counts", int'(block_cnt_o) + int'(chunk_cnt_o) + int'(out_data_o != 0), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // ECB, two blocks, stalls on both streams, core = bitwise inversion
        core_key = '1;
        stall_en = 1;
        exp_core_q.push_back(128'h00000000_11111111_22222222_33333333);
        exp_core_q.push_back(128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF);
        push_block_out(128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC);
        push_block_out(128'h21524110_35014541_FEDCBA98_76543210);
        prev = done_cnt;
        cs   = core_starts;
        start_job(2, 2'b00, '0);
        send_block(128'h00000000_11111111_22222222_33333333, 2);
        send_block(128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, 2);
        wait_done(prev);
        check_int("ecb_block_cnt", int'(block_cnt_o), 2);
        repeat (3) @(negedge clk_i);
        check_int("ecb_core_starts", core_starts - cs, 2);
        check_int("ecb_done_pulses", done_cnt - prev, 1);
        stall_en = 0;

        // CBC-encrypt, identity core; a start pulse mid-job must be ignored
        core_key = '0;
        exp_core_q.push_back(128'h11101312_26272425_3B3A3938_48494A4B);
        exp_core_q.push_back(128'hEEEFECED_26272425_C4C5C6C7_48494A4B);
        push_block_out(128'h11101312_26272425_3B3A3938_48494A4B);
        push_block_out(128'hEEEFECED_26272425_C4C5C6C7_48494A4B);
        prev = done_cnt;
        start_job(2, 2'b01, IV);
        send_block(128'h11111111_22222222_33333333_44444444, 0);
        start_job(7, 2'b10, '1);
        send_block(128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 0);
        wait_done(prev);
        check_int("cbce_block_cnt", int'(block_cnt_o), 2);
        repeat (2) @(negedge clk_i);

        // CBC-decrypt, identity core
        exp_core_q.push_back(128'hA5A5A5A5_5A5A5A5A_00000000_FFFFFFFF);
        exp_core_q.push_back(128'h01234567_89ABCDEF_FEDCBA98_76543210);
        push_block_out(128'hA5A4A7A6_5E5F5C5D_08090A0B_F3F2F1F0);
        push_block_out(128'hA486E0C2_D3F197B5_FEDCBA98_89ABCDEF);
        prev = done_cnt;
        start_job(2, 2'b10, IV);
        send_block(128'hA5A5A5A5_5A5A5A5A_00000000_FFFFFFFF, 1);
        send_block(128'h01234567_89ABCDEF_FEDCBA98_76543210, 0);
        wait_done(prev);
        repeat (2) @(negedge clk_i);

        // Zero-length job: straight to FINISHED, one done pulse, no traffic
        cs = core_starts;
        start_job(0, 2'b00, '0);
        check_int("zero_done_high", int'(done_o), 1);
        check_int("zero_busy_high", int'(busy_o), 1);
        check_int("zero_in_ready", int'(in_ready_o), 0);
        check_int("zero_block_cnt", int'(block_cnt_o), 0);
        @(negedge clk_i);
        check_int("zero_done_low", int'(done_o), 0);
        check_int("zero_busy_low", int'(busy_o), 0);
        check_int("zero_core_starts", core_starts - cs, 0);

        // Soft clear while the core is busy, then a late core_done
        core_hold = 1;
        core_key  = '1;
        exp_core_q.push_back(128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF);
        prev = done_cnt;
        start_job(1, 2'b00, '0);
        send_block(128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, 0);
        @(negedge clk_i);
        check_int("clr_pre_busy", int'(busy_o), 1);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check_int("clr_busy", int'(busy_o), 0);
        check("clr_core_data", core_data_o, '0);
        repeat (2) @(negedge clk_i);
        core_result_i = '1;
        core_done_i   = 1'b1;
        @(negedge clk_i);
        core_done_i   = 1'b0;
        repeat (4) @(negedge clk_i);
        check_int("clr_late_busy", int'(busy_o), 0);
        check_int("clr_no_done", done_cnt - prev, 0);
        core_hold = 0;
        exp_core_q.push_back(128'h00000000_11111111_22222222_33333333);
        push_block_out(128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC);
        start_job(1, 2'b00, '0);
        send_block(128'h00000000_11111111_22222222_33333333, 0);
        wait_done(prev);
        check_int("clr_new_job_cnt", int'(block_cnt_o), 1);
        repeat (2) @(negedge clk_i);

        // Asynchronous reset between edges while draining
        ready_force0 = 1;
        exp_core_q.push_back(128'h00000000_11111111_22222222_33333333);
        prev = done_cnt;
        start_job(1, 2'b00, '0);
        send_block(128'h00000000_11111111_22222222_33333333, 0);
        t = 0;
        while (!out_valid_o && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 500) timeout_fail("drain_wait");
        #2;
        rst_i = 1'b1;
        #1;
        check_int("arst_out_valid", int'(out_valid_o), 0);
        check_int("arst_busy", int'(busy_o), 0);
        check("arst_out_data", BW'(out_data_o), '0);
        check("arst_core_data", core_data_o, '0);
        num_blocks_i = 1;
        start_i      = 1'b1;
        repeat (2) @(negedge clk_i);
        check_int("arst_start_ignored", int'(busy_o), 0);
        start_i      = 1'b0;
        rst_i        = 1'b0;
        ready_force0 = 0;
        @(negedge clk_i);
        exp_core_q.push_back(128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF);
        push_block_out(128'h21524110_35014541_FEDCBA98_76543210);
        start_job(1, 2'b00, '0);
        send_block(128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, 0);
        wait_done(prev);
        repeat (3) @(negedge clk_i);
        check_int("arst_done_once", done_cnt - prev, 1);

        check_int("out_queue_empty", exp_out_q.size(), 0);
        check_int("core_queue_empty", exp_core_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
